// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation codes
// (also used by the ALU decoder), FSM state encoding and small decode helpers.
package muldiv_pkg;

    localparam logic [4:0] SEL_MUL    = 5'b01000;
    localparam logic [4:0] SEL_MULH   = 5'b01001;
    localparam logic [4:0] SEL_MULHU  = 5'b01010;
    localparam logic [4:0] SEL_MULHSU = 5'b01011;
    localparam logic [4:0] SEL_DIV    = 5'b01100;
    localparam logic [4:0] SEL_DIVU   = 5'b01101;
    localparam logic [4:0] SEL_REM    = 5'b01110;
    localparam logic [4:0] SEL_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the four divide/remainder codes (01100..01111).
    function automatic logic is_div_op(input logic [4:0] sel);
        return (sel[4:2] == 3'b011);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath. The 2*WIDTH product register holds
// {accumulator/remainder, multiplier/dividend}.
//   multiply: add the multiplicand to the upper half when the current LSB of
//             the multiplier is set, then shift the whole register right.
//   divide:   shift the register left by one, try to subtract the divisor from
//             the upper part, and shift the resulting quotient bit into bit 0.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     operand,
    input  logic [2*WIDTH-1:0]   prod_in,
    output logic [2*WIDTH-1:0]   prod_out
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             q_bit;

    // Single shift-add or restore step, selected by operation class.
    always_comb begin
        add_sum   = {1'b0, prod_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // Partial remainder after shifting in the next dividend bit; needs one
        // extra bit because it can momentarily reach twice the divisor.
        rem_shift = prod_in[2*WIDTH-1:WIDTH-1];
        q_bit     = (rem_shift >= {1'b0, operand});
        // Only the low WIDTH bits survive when the subtraction is taken.
        rem_sub   = rem_shift[WIDTH-1:0] - operand;
        prod_out  = prod_in;
        if (is_div) begin
            prod_out = {(q_bit ? rem_sub : rem_shift[WIDTH-1:0]),
                        prod_in[WIDTH-2:0], q_bit};
        end else if (prod_in[0]) begin
            prod_out = {add_sum, prod_in[WIDTH-1:1]};
        end else begin
            prod_out = {1'b0, prod_in[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. Operands are reduced
// to magnitudes at acceptance, 32 unsigned iterations run in CALC, and the
// sign is restored on the edge that enters DONE. Divide-by-zero, signed
// overflow and unknown opcodes are resolved at acceptance and bypass CALC.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             FLUSH,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int               PW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0]       op_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [PW-1:0]    prod_reg;
    logic [WIDTH-1:0] result_reg;

    logic             sign1, sign2;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] acc_opnd, acc_lo;
    logic             acc_neg;
    logic             acc_special;
    logic [WIDTH-1:0] acc_special_result;

    logic             accept;
    logic             finish;
    logic [PW-1:0]    step_prod;
    logic [PW-1:0]    mul_full;
    logic [WIDTH-1:0] div_q, div_r;
    logic [WIDTH-1:0] fin_result;

    // Decode a request: pick operand magnitudes, result sign and special cases.
    always_comb begin
        sign1              = DATA1[WIDTH-1];
        sign2              = DATA2[WIDTH-1];
        abs1               = sign1 ? -DATA1 : DATA1;
        abs2               = sign2 ? -DATA2 : DATA2;
        acc_opnd           = DATA1;
        acc_lo             = DATA2;
        acc_neg            = 1'b0;
        acc_special        = 1'b0;
        acc_special_result = '0;
        case (SELECT)
            SEL_MUL, SEL_MULHU: begin
                acc_opnd = DATA1;
                acc_lo   = DATA2;
            end
            SEL_MULH: begin
                acc_opnd = abs1;
                acc_lo   = abs2;
                acc_neg  = sign1 ^ sign2;
            end
            SEL_MULHSU: begin
                acc_opnd = abs1;
                acc_lo   = DATA2;
                acc_neg  = sign1;
            end
            SEL_DIV: begin
                acc_opnd = abs2;
                acc_lo   = abs1;
                acc_neg  = sign1 ^ sign2;
                if (DATA2 == '0) begin
                    acc_special        = 1'b1;
                    acc_special_result = ALL_ONES;
                end else if ((DATA1 == MIN_NEG) && (DATA2 == ALL_ONES)) begin
                    acc_special        = 1'b1;
                    acc_special_result = MIN_NEG;
                end
            end
            SEL_DIVU: begin
                acc_opnd = DATA2;
                acc_lo   = DATA1;
                if (DATA2 == '0) begin
                    acc_special        = 1'b1;
                    acc_special_result = ALL_ONES;
                end
            end
            SEL_REM: begin
                acc_opnd = abs2;
                acc_lo   = abs1;
                acc_neg  = sign1;
                if (DATA2 == '0) begin
                    acc_special        = 1'b1;
                    acc_special_result = DATA1;
                end else if ((DATA1 == MIN_NEG) && (DATA2 == ALL_ONES)) begin
                    acc_special        = 1'b1;
                    acc_special_result = '0;
                end
            end
            SEL_REMU: begin
                acc_opnd = DATA2;
                acc_lo   = DATA1;
                if (DATA2 == '0) begin
                    acc_special        = 1'b1;
                    acc_special_result = DATA1;
                end
            end
            default: begin
                acc_special        = 1'b1;
                acc_special_result = '0;
            end
        endcase
    end

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (is_div_op(op_reg)),
        .operand  (opnd_reg),
        .prod_in  (prod_reg),
        .prod_out (step_prod)
    );

    // Sign fix-up and result selection applied to the output of the last step.
    always_comb begin
        mul_full   = neg_reg ? -step_prod : step_prod;
        div_q      = step_prod[WIDTH-1:0];
        div_r      = step_prod[PW-1:WIDTH];
        fin_result = '0;
        case (op_reg)
            SEL_MUL:                       fin_result = mul_full[WIDTH-1:0];
            SEL_MULH, SEL_MULHU, SEL_MULHSU: fin_result = mul_full[PW-1:WIDTH];
            SEL_DIV, SEL_DIVU:             fin_result = neg_reg ? -div_q : div_q;
            SEL_REM, SEL_REMU:             fin_result = neg_reg ? -div_r : div_r;
            default:                       fin_result = '0;
        endcase
    end

    // Next-state logic; FLUSH wins over START and aborts any calculation.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!FLUSH && START) begin
                    accept     = 1'b1;
                    state_next = acc_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (FLUSH) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (FLUSH) begin
                    state_next = ST_IDLE;
                end else if (START) begin
                    accept     = 1'b1;
                    state_next = acc_special ? ST_DONE : ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: load on acceptance, iterate in CALC, capture result into DONE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            opnd_reg   <= '0;
            prod_reg   <= '0;
            result_reg <= '0;
        end else if (accept) begin
            op_reg   <= SELECT;
            neg_reg  <= acc_neg;
            opnd_reg <= acc_opnd;
            prod_reg <= {{WIDTH{1'b0}}, acc_lo};
            cnt_reg  <= '0;
            if (acc_special) begin
                result_reg <= acc_special_result;
            end
        end else if ((state_reg == ST_CALC) && !FLUSH) begin
            prod_reg <= step_prod;
            cnt_reg  <= cnt_reg + CNT_W'(1);
            if (finish) begin
                result_reg <= fin_result;
            end
        end
    end

    assign RESULT = result_reg;
    assign BUSY   = (state_reg == ST_CALC);
    assign DONE   = (state_reg == ST_DONE);

endmodule
